// File: rtl/vec_pkg.sv
// Shared encodings and vector types for the vector write-back path.
package vec_pkg;

  localparam int N = 16;
  localparam int M = 16;

  localparam logic [1:0] SEL_SRC0 = 2'b00;
  localparam logic [1:0] SEL_SRC1 = 2'b01;
  localparam logic [1:0] SEL_SRC2 = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef logic [N-1:0] lane_t;
  typedef lane_t [M-1:0] vec_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin grant with a bounded burst allowance for the last winner.
module rr_arb3
  import vec_pkg::*;
#(
  parameter int BURST = 4,
  parameter int BCW   = 3
) (
  input  logic [2:0]     req_valid,
  input  logic [1:0]     last,
  input  logic [BCW-1:0] burst_cnt,
  output logic [2:0]     grant,
  output logic [1:0]     gnt_idx
);

  localparam logic [BCW-1:0] BURST_MAX = BCW'(BURST);

  logic       stay;
  logic       found;
  logic [1:0] cand;

  function automatic logic [1:0] wrap_add(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return 2'(s % 3);
  endfunction

  // burst_cnt==0 means nobody has been granted since reset, so no repeat credit
  assign stay = req_valid[last] && (burst_cnt != '0) && (burst_cnt < BURST_MAX);

  always_comb begin
    grant   = '0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    found   = 1'b0;
    if (stay) begin
      grant[last] = 1'b1;
      gnt_idx     = last;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        cand = wrap_add(last, k);
        if (!found && req_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          gnt_idx     = cand;
        end
      end
    end
  end

endmodule

// File: rtl/vec_wb_arbiter.sv
// Round-robin arbiter feeding a one-entry registered write-back stage
// from three vector producers (ALU, load, scalar broadcast).
module vec_wb_arbiter
  import vec_pkg::*;
#(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int AW    = 4,
  parameter int BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [M-1:0][N-1:0] req_data0,
  input  logic [M-1:0][N-1:0] req_data1,
  input  logic [M-1:0][N-1:0] req_data2,
  input  logic [AW-1:0]       req_addr0,
  input  logic [AW-1:0]       req_addr1,
  input  logic [AW-1:0]       req_addr2,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [M-1:0][N-1:0] wb_data,
  output logic [AW-1:0]       wb_addr,
  output logic [1:0]          wb_sel
);

  localparam int BCW = $clog2(BURST + 1);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(BURST);
  localparam logic [BCW-1:0] BCNT_ONE  = BCW'(1);

  wb_state_e           state_q, state_d;
  logic [M-1:0][N-1:0] wb_data_q, wb_data_d, mux_data;
  logic [AW-1:0]       wb_addr_q, wb_addr_d, mux_addr;
  logic [1:0]          wb_sel_q, wb_sel_d, mux_sel;
  logic [1:0]          last_q, last_d;
  logic [BCW-1:0]      burst_q, burst_d;
  logic [2:0]          grant;
  logic [1:0]          gnt_idx;
  logic                accept;
  logic                xfer;

  rr_arb3 #(.BURST(BURST), .BCW(BCW)) u_arb (
    .req_valid (req_valid),
    .last      (last_q),
    .burst_cnt (burst_q),
    .grant     (grant),
    .gnt_idx   (gnt_idx)
  );

  // rst_n gate keeps req_ready low while reset is asserted even though state is EMPTY
  assign accept    = rst_n & ((state_q == ST_EMPTY) | wb_ready);
  assign req_ready = grant & {3{accept}};
  assign xfer      = |req_ready;

  always_comb begin
    case (gnt_idx)
      2'd0: begin mux_data = req_data0; mux_addr = req_addr0; mux_sel = SEL_SRC0; end
      2'd1: begin mux_data = req_data1; mux_addr = req_addr1; mux_sel = SEL_SRC1; end
      default: begin mux_data = req_data2; mux_addr = req_addr2; mux_sel = SEL_SRC2; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    wb_sel_d  = wb_sel_q;
    last_d    = last_q;
    burst_d   = burst_q;
    if (xfer) begin
      state_d   = ST_FULL;
      wb_data_d = mux_data;
      wb_addr_d = mux_addr;
      wb_sel_d  = mux_sel;
      last_d    = gnt_idx;
      if ((gnt_idx != last_q) || (burst_q == '0)) begin
        burst_d = BCNT_ONE;
      end else if (burst_q != BURST_MAX) begin
        burst_d = burst_q + BCNT_ONE;
      end
    end else if ((state_q == ST_FULL) && wb_ready) begin
      state_d  = ST_EMPTY;
      wb_sel_d = SEL_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      wb_sel_q  <= SEL_NONE;
      last_q    <= 2'd2;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      wb_sel_q  <= wb_sel_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
    end
  end

  assign wb_valid = (state_q == ST_FULL);
  assign wb_data  = wb_data_q;
  assign wb_addr  = wb_addr_q;
  assign wb_sel   = wb_sel_q;

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Bench for vec_wb_arbiter: two instances (BURST=4 and BURST=1) on shared stimulus,
// hand-derived grant tables plus per-instance output-stage scoreboards.
module tb_vec_wb_arbiter;

  localparam int N  = 16;
  localparam int M  = 16;
  localparam int AW = 4;

  typedef logic [255:0] w_t;

  typedef struct packed {
    logic [1:0]          sel;
    logic [AW-1:0]       addr;
    logic [M-1:0][N-1:0] data;
  } beat_t;

  typedef struct {
    logic       rst;
    logic [2:0] rv;
    logic       rdy;
    logic [2:0] ea;
    logic [2:0] eb;
  } vec_rec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [2:0]          req_valid = 3'b000;
  logic                wb_ready = 1'b0;
  logic [M-1:0][N-1:0] data_s [3];
  logic [AW-1:0]       addr_s [3];

  logic [2:0]          rr_a, rr_b;
  logic                v_a, v_b;
  logic [M-1:0][N-1:0] d_a, d_b;
  logic [AW-1:0]       ad_a, ad_b;
  logic [1:0]          s_a, s_b;

  int    checks = 0;
  int    errors = 0;
  beat_t qa[$];
  beat_t qb[$];

  always #5 clk = ~clk;

  vec_wb_arbiter #(.N(N), .M(M), .AW(AW), .BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr_a),
    .req_data0(data_s[0]), .req_data1(data_s[1]), .req_data2(data_s[2]),
    .req_addr0(addr_s[0]), .req_addr1(addr_s[1]), .req_addr2(addr_s[2]),
    .wb_valid(v_a), .wb_ready(wb_ready), .wb_data(d_a), .wb_addr(ad_a), .wb_sel(s_a)
  );

  vec_wb_arbiter #(.N(N), .M(M), .AW(AW), .BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr_b),
    .req_data0(data_s[0]), .req_data1(data_s[1]), .req_data2(data_s[2]),
    .req_addr0(addr_s[0]), .req_addr1(addr_s[1]), .req_addr2(addr_s[2]),
    .wb_valid(v_b), .wb_ready(wb_ready), .wb_data(d_b), .wb_addr(ad_b), .wb_sel(s_b)
  );

  task automatic chk(input string nm, input w_t got, input w_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [1:0] s,
                         input logic [AW-1:0] a, input logic [M-1:0][N-1:0] d,
                         input logic ev, input beat_t eb);
    chk({nm, " wb_valid"}, w_t'(v), w_t'(ev));
    if (ev) begin
      chk({nm, " wb_sel"}, w_t'(s), w_t'(eb.sel));
      chk({nm, " wb_addr"}, w_t'(a), w_t'(eb.addr));
      chk({nm, " wb_data"}, w_t'(d), w_t'(eb.data));
    end else begin
      chk({nm, " wb_sel empty"}, w_t'(s), w_t'(2'b11));
    end
  endtask

  function automatic beat_t mk_beat(input logic [2:0] g);
    int i;
    beat_t b;
    i = g[0] ? 0 : (g[1] ? 1 : 2);
    b.sel  = 2'(i);
    b.addr = addr_s[i];
    b.data = data_s[i];
    return b;
  endfunction

  task automatic check_outputs(input string nm);
    beat_t ha, hb;
    ha = (qa.size() > 0) ? qa[0] : '0;
    hb = (qb.size() > 0) ? qb[0] : '0;
    chk_out({nm, " A"}, v_a, s_a, ad_a, d_a, qa.size() > 0, ha);
    chk_out({nm, " B"}, v_b, s_b, ad_b, d_b, qb.size() > 0, hb);
  endtask

  task automatic step(input logic [2:0] rv, input logic rdy,
                      input logic [2:0] ea, input logic [2:0] eb, input string nm);
    @(negedge clk);
    req_valid = rv;
    wb_ready  = rdy;
    #1;
    chk({nm, " A req_ready"}, w_t'(rr_a), w_t'(ea));
    chk({nm, " B req_ready"}, w_t'(rr_b), w_t'(eb));
    if (qa.size() > 0 && rdy) void'(qa.pop_front());
    if (qb.size() > 0 && rdy) void'(qb.pop_front());
    if (ea != 3'b000) qa.push_back(mk_beat(ea));
    if (eb != 3'b000) qb.push_back(mk_beat(eb));
    @(posedge clk);
    #1;
    check_outputs(nm);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, " A req_ready"}, w_t'(rr_a), w_t'(3'b000));
    chk({nm, " B req_ready"}, w_t'(rr_b), w_t'(3'b000));
    chk({nm, " A wb_valid"}, w_t'(v_a), w_t'(1'b0));
    chk({nm, " A wb_sel"}, w_t'(s_a), w_t'(2'b11));
    chk({nm, " A wb_addr"}, w_t'(ad_a), w_t'(0));
    chk({nm, " A wb_data"}, w_t'(d_a), w_t'(0));
    chk({nm, " B wb_valid"}, w_t'(v_b), w_t'(1'b0));
    chk({nm, " B wb_sel"}, w_t'(s_b), w_t'(2'b11));
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 3'b111;
    wb_ready  = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    check_reset_state(nm);
    @(negedge clk);
    req_valid = 3'b000;
    rst_n     = 1'b1;
  endtask

  task automatic gen_payload(input int k);
    for (int i = 0; i < 3; i++) begin
      addr_s[i] = AW'(i * 5 + k);
      for (int j = 0; j < M; j++) data_s[i][j] = N'(i * 4096 + k * 16 + j);
    end
  endtask

  vec_rec_t tbl[$];

  task automatic add(input logic r, input logic [2:0] rv, input logic rdy,
                     input logic [2:0] ea, input logic [2:0] eb);
    vec_rec_t t;
    t.rst = r; t.rv = rv; t.rdy = rdy; t.ea = ea; t.eb = eb;
    tbl.push_back(t);
  endtask

  initial begin
    // all three requesting: A bursts 4 from source 0, B rotates every beat
    add(1, 3'b111, 1, 3'b001, 3'b001);
    add(0, 3'b111, 1, 3'b001, 3'b010);
    add(0, 3'b111, 1, 3'b001, 3'b100);
    add(0, 3'b111, 1, 3'b001, 3'b001);
    add(0, 3'b111, 1, 3'b010, 3'b010);
    add(0, 3'b111, 1, 3'b010, 3'b100);
    // sources 0 and 1: A alternates in runs of four, B alternates every beat
    add(1, 3'b011, 1, 3'b001, 3'b001);
    add(0, 3'b011, 1, 3'b001, 3'b010);
    add(0, 3'b011, 1, 3'b001, 3'b001);
    add(0, 3'b011, 1, 3'b001, 3'b010);
    add(0, 3'b011, 1, 3'b010, 3'b001);
    add(0, 3'b011, 1, 3'b010, 3'b010);
    add(0, 3'b011, 1, 3'b010, 3'b001);
    add(0, 3'b011, 1, 3'b010, 3'b010);
    add(0, 3'b011, 1, 3'b001, 3'b001);
    // lone requester granted every cycle past the burst limit
    for (int i = 0; i < 6; i++) add(0, 3'b001, 1, 3'b001, 3'b001);
    // backpressure: held beat stable, then drain and fill in one cycle
    for (int i = 0; i < 3; i++) add(0, 3'b011, 0, 3'b000, 3'b000);
    add(0, 3'b011, 1, 3'b010, 3'b010);
    add(0, 3'b000, 1, 3'b000, 3'b000);
    // withdrawn request from source 2 while stalled
    add(0, 3'b001, 1, 3'b001, 3'b001);
    add(0, 3'b100, 0, 3'b000, 3'b000);
    add(0, 3'b000, 1, 3'b000, 3'b000);
    add(0, 3'b000, 1, 3'b000, 3'b000);

    gen_payload(0);
    do_reset("reset");

    for (int i = 0; i < 3; i++) begin
      addr_s[i] = '0;
      data_s[i] = '0;
    end
    addr_s[0] = AW'(5);
    for (int j = 0; j < M; j++) data_s[0][j] = 16'h1111;
    step(3'b001, 1'b1, 3'b001, 3'b001, "single");
    chk("single addr", w_t'(ad_a), w_t'(5));
    chk("single lane", w_t'(d_a[M-1]), w_t'(16'h1111));
    step(3'b000, 1'b1, 3'b000, 3'b000, "single drain");
    chk("drain addr hold", w_t'(ad_a), w_t'(5));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset($sformatf("reset v%0d", i));
      gen_payload(i + 1);
      step(tbl[i].rv, tbl[i].rdy, tbl[i].ea, tbl[i].eb, $sformatf("v%0d", i));
    end

    // asynchronous reset while holding a stalled beat
    gen_payload(100);
    step(3'b001, 1'b1, 3'b001, 3'b001, "pre-reset fill");
    gen_payload(101);
    step(3'b011, 1'b0, 3'b000, 3'b000, "pre-reset stall");
    #3;
    rst_n     = 1'b0;
    req_valid = 3'b111;
    qa.delete();
    qb.delete();
    #1;
    check_reset_state("async reset");
    @(negedge clk);
    req_valid = 3'b000;
    rst_n     = 1'b1;
    gen_payload(102);
    step(3'b111, 1'b1, 3'b001, 3'b001, "post-reset");
    step(3'b000, 1'b1, 3'b000, 3'b000, "post-reset drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
